muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.

---
 rtl/muldiv_if.sv | 35 +++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//
// Handshake: the requester raises start with Funct/op_a/op_b valid and holds
// them until it sees busy=0; the unit samples start only while busy=0.
// When a MULT/DIV finishes, busy drops and done pulses for exactly one cycle.
// flush cancels whatever is in flight on the next edge.
//
// Signals:
//   start, Funct, op_a, op_b, flush : requester -> unit
//   busy, done, hi, lo              : unit -> requester
//   dbg_state                       : unit FSM state, for observation only
interface muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [5:0]        Funct;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [1:0]        dbg_state;

    modport master (
        output start, Funct, op_a, op_b, flush,
        input  busy, done, hi, lo, dbg_state
    );

    modport slave (
        input  start, Funct, op_a, op_b, flush,
        output busy, done, hi, lo, dbg_state
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state
//   bus    muldiv_if slave: start/Funct/op_a/op_b/flush in,
//          busy/done/hi/lo/dbg_state out
//
// MULT/MULTU: the full product is computed from latched operands and written
// into {hi,lo} after MUL_CYCLES edges. DIV/DIVU: restoring divider on operand
// magnitudes, one quotient bit per edge for DATA_W edges, then one edge that
// applies signs (quotient truncates toward zero, remainder follows dividend).
// MTHI/MTLO write HI/LO directly without going busy.
module muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_MAX = (DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;

    // opa_r: multiplicand, or raw dividend (needed for the divide-by-zero hi).
    // opb_r: multiplier, or divisor magnitude.
    logic [DATA_W-1:0] opa_r;
    logic [DATA_W-1:0] opb_r;
    logic              sgn_r;
    logic [DATA_W-1:0] quo_r;    // dividend bits shift out, quotient bits shift in
    logic [DATA_W:0]   rem_r;    // one extra bit so the trial subtract shows its borrow
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;

    logic              signed_op;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [2*DATA_W-1:0] mul_a_ext;
    logic [2*DATA_W-1:0] mul_b_ext;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   rem_diff;

    always_comb begin
        signed_op = ~bus.Funct[0];
        abs_a     = (signed_op && bus.op_a[DATA_W-1]) ? -bus.op_a : bus.op_a;
        abs_b     = (signed_op && bus.op_b[DATA_W-1]) ? -bus.op_b : bus.op_b;
        // Sign- or zero-extend to 2*DATA_W so one unsigned multiply serves both.
        mul_a_ext = {{DATA_W{sgn_r & opa_r[DATA_W-1]}}, opa_r};
        mul_b_ext = {{DATA_W{sgn_r & opb_r[DATA_W-1]}}, opb_r};
        product   = mul_a_ext * mul_b_ext;
        rem_shift = {rem_r[DATA_W-1:0], quo_r[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, opb_r};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            opa_r    <= '0;
            opb_r    <= '0;
            sgn_r    <= 1'b0;
            quo_r    <= '0;
            rem_r    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.flush) begin
                // Squash wins over completion and over a new request.
                state  <= IDLE;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            case (bus.Funct)
                                F_MTHI: hi_r <= bus.op_a;
                                F_MTLO: lo_r <= bus.op_a;
                                F_MULT, F_MULTU: begin
                                    opa_r  <= bus.op_a;
                                    opb_r  <= bus.op_b;
                                    sgn_r  <= signed_op;
                                    cnt    <= CNT_W'(MUL_CYCLES - 1);
                                    state  <= MUL;
                                    busy_r <= 1'b1;
                                end
                                F_DIV, F_DIVU: begin
                                    opa_r    <= bus.op_a;
                                    opb_r    <= abs_b;
                                    quo_r    <= abs_a;
                                    rem_r    <= '0;
                                    neg_q    <= signed_op & (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]);
                                    neg_r    <= signed_op & bus.op_a[DATA_W-1];
                                    div_zero <= (bus.op_b == '0);
                                    cnt      <= CNT_W'(DATA_W);
                                    state    <= DIV;
                                    busy_r   <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        if (cnt == '0) begin
                            {hi_r, lo_r} <= product;
                            state        <= IDLE;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    DIV: begin
                        if (cnt != '0) begin
                            if (!rem_diff[DATA_W]) begin
                                rem_r <= rem_diff;
                                quo_r <= {quo_r[DATA_W-2:0], 1'b1};
                            end else begin
                                rem_r <= rem_shift;
                                quo_r <= {quo_r[DATA_W-2:0], 1'b0};
                            end
                            cnt <= cnt - 1'b1;
                        end else begin
                            // MIN / -1 falls out naturally: |MIN| / 1 = MIN, sign stays.
                            if (div_zero) begin
                                lo_r <= '1;
                                hi_r <= opa_r;
                            end else begin
                                lo_r <= neg_q ? -quo_r : quo_r;
                                hi_r <= neg_r ? -rem_r[DATA_W-1:0] : rem_r[DATA_W-1:0];
                            end
                            state  <= IDLE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int DATA_W     = 32;
    localparam int MUL_CYCLES = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [63:0] exp_q[$];

    muldiv_if #(.DATA_W(DATA_W)) bus ();

    muldiv_unit #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Independent reference for random operations.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        int sa, sb;
        model = '0;
        sa = a;
        sb = b;
        case (f)
            6'h18: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                model = sp;
            end
            6'h19: model = {32'h0, a} * {32'h0, b};
            6'h1A: begin
                if (b == 32'h0)                              model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
                else                                         model = {32'(sa % sb), 32'(sa / sb)};
            end
            6'h1B: begin
                if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
                else            model = {a % b, a / b};
            end
            default: model = '0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] expv, input int exp_cycles);
        int cycles;
        logic [63:0] want;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.Funct = f;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(cycles), 64'(exp_cycles));
        chk({tag, " done"}, 64'(bus.done), 64'd1);
        want = exp_q.pop_front();
        chk({tag, " hilo"}, {bus.hi, bus.lo}, want);
        @(negedge clk);
        chk({tag, " done_drop"}, 64'(bus.done), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0]  f;
        logic [31:0] a, b;
        int          done_seen;
        int          cycles;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.Funct = 6'h0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset hilo", {bus.hi, bus.lo}, 64'd0);
        chk("reset state", 64'(bus.dbg_state), 64'd0);
        reset = 1'b0;

        run_op("mult_neg3x7", 6'h18, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 4);
        run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4);
        run_op("div_neg7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("divu_7_2", 6'h1B, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 33);
        run_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);
        run_op("divu_by0", 6'h1B, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 33);
        run_op("div_by0", 6'h1A, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 33);
        run_op("div_pos_neg", 6'h1A, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33);

        // MTHI then MTLO on consecutive cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.Funct = 6'h11; bus.op_a = 32'h1234;
        @(negedge clk);
        chk("mthi hi", 64'(bus.hi), 64'h1234);
        chk("mthi busy", 64'(bus.busy), 64'd0);
        bus.Funct = 6'h13; bus.op_a = 32'h5678;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);
        chk("mtlo busy", 64'(bus.busy), 64'd0);
        chk("mtlo done", 64'(bus.done), 64'd0);

        // Unknown Funct is ignored.
        bus.start = 1'b1; bus.Funct = 6'h20; bus.op_a = 32'hAAAA;
        @(negedge clk);
        bus.start = 1'b0;
        chk("bad_funct busy", 64'(bus.busy), 64'd0);
        chk("bad_funct hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);

        // Random operations against the reference model.
        for (int i = 0; i < 8; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (i == 3) b = 32'd0;
            run_op($sformatf("rand%0d", i), f, a, b, model(f, a, b), (f[1]) ? 33 : 4);
        end

        // start held during busy with a different request: no effect.
        exp_q.push_back(64'd15);
        @(negedge clk);
        bus.start = 1'b1; bus.Funct = 6'h19; bus.op_a = 32'd3; bus.op_b = 32'd5;
        @(negedge clk);
        bus.Funct = 6'h11; bus.op_a = 32'hDEAD;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        chk("busy_start done", 64'(bus.done), 64'd1);
        chk("busy_start hilo", {bus.hi, bus.lo}, exp_q.pop_front());

        // flush together with start in IDLE: start ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.Funct = 6'h11; bus.op_a = 32'hBEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_idle hilo", {bus.hi, bus.lo}, 64'd15);
        chk("flush_idle busy", 64'(bus.busy), 64'd0);

        // flush mid-DIV: busy drops, no done, HI/LO kept.
        bus.start = 1'b1; bus.Funct = 6'h1B; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_div busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_div busy_after", 64'(bus.busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        chk("flush_div no_done", 64'(done_seen), 64'd0);
        chk("flush_div hilo", {bus.hi, bus.lo}, 64'd15);

        // Reset asserted mid-MUL clears immediately.
        bus.start = 1'b1; bus.Funct = 6'h18; bus.op_a = 32'd5; bus.op_b = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_mid busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid busy", 64'(bus.busy), 64'd0);
        chk("rst_mid hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_mid state", 64'(bus.dbg_state), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_reset", 6'h19, 32'd9, 32'd11, 64'd99, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
